// File: rtl/dt_walker_pkg.sv
// dt_walker_pkg: width helpers, node-word field slicing, FSM states and the thermometer encoder.
package dt_walker_pkg;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  // Wide carrier so the slicing helpers work for any legal parameter set.
  typedef logic [63:0] word_t;
  function automatic int addr_w(input int n_nodes);
    return n_nodes > 2 ? $clog2(n_nodes) : 1;
  endfunction
  function automatic int fidx_w(input int n_feat);
    return n_feat > 2 ? $clog2(n_feat) : 1;
  endfunction
  function automatic int lvl_w(input int n_out);
    return $clog2(n_out + 1);
  endfunction
  function automatic int node_w(input int aw, input int fw);
    return 1 + fw + 2 * aw;
  endfunction
  function automatic word_t mask(input int n);
    return (word_t'(1) << n) - word_t'(1);
  endfunction
  function automatic logic is_leaf(input word_t w, input int nw);
    return |((w >> (nw - 1)) & word_t'(1));
  endfunction
  function automatic word_t fidx(input word_t w, input int aw, input int fw);
    return (w >> (2 * aw)) & mask(fw);
  endfunction
  function automatic word_t child_hi(input word_t w, input int aw);
    return (w >> aw) & mask(aw);
  endfunction
  function automatic word_t child_lo(input word_t w, input int aw);
    return w & mask(aw);
  endfunction
  function automatic word_t leaf_lvl(input word_t w, input int lw);
    return w & mask(lw);
  endfunction
  // Levels beyond the output width saturate to all ones.
  function automatic word_t lvl_to_therm(input word_t l, input int n_out);
    return mask(l > word_t'(n_out) ? n_out : int'(l));
  endfunction
endpackage

// File: rtl/dt_node_table.sv
// dt_node_table: node register array, sync write, combinational read, async clear.
//   clk, rst_n        clock, async active-low reset (clears every node)
//   we, waddr, wdata  write port
//   raddr, rdata      combinational read port
module dt_node_table
  import dt_walker_pkg::*;
#(
  parameter int N_NODES = 64,
  parameter int NODE_W  = 17,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NODE_W-1:0] rdata
);
  logic [NODE_W-1:0] mem [N_NODES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N_NODES; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dt_walker.sv
// dt_walker: sequential decision-tree walker over a loadable node table, thermometer-coded result.
//   clk, rst_n                     clock, async active-low reset
//   cfg_we, cfg_addr, cfg_wdata    node table write (IDLE only); cfg_err pulses on rejection
//   in_valid, in_ready, inp        feature vector handshake
//   out_valid, out_ready, outp     result handshake, thermometer-coded class
//   out_err                        walk aborted on depth overflow
module dt_walker
  import dt_walker_pkg::*;
#(
  parameter int N_FEAT    = 10,
  parameter int N_OUT     = 10,
  parameter int N_NODES   = 64,
  parameter int MAX_DEPTH = 16,
  localparam int ADDR_W = addr_w(N_NODES),
  localparam int FIDX_W = fidx_w(N_FEAT),
  localparam int LVL_W  = lvl_w(N_OUT),
  localparam int NODE_W = node_w(ADDR_W, FIDX_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [NODE_W-1:0] cfg_wdata,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] inp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  outp,
  output logic              out_err
);
  localparam int STEP_W = $clog2(MAX_DEPTH + 1);
  state_t state, nxt;
  logic [N_FEAT-1:0] feat;
  logic [ADDR_W-1:0] cur, hi, lo;
  logic [STEP_W-1:0] step;
  logic [NODE_W-1:0] node;
  logic [FIDX_W-1:0] fi;
  logic leaf, bit_sel, abort;
  dt_node_table #(.N_NODES(N_NODES), .NODE_W(NODE_W), .ADDR_W(ADDR_W)) u_table (
    .clk(clk), .rst_n(rst_n), .we(cfg_we && state == IDLE), .waddr(cfg_addr),
    .wdata(cfg_wdata), .raddr(cur), .rdata(node)
  );
  assign leaf      = is_leaf(word_t'(node), NODE_W);
  assign fi        = FIDX_W'(fidx(word_t'(node), ADDR_W, FIDX_W));
  assign hi        = ADDR_W'(child_hi(word_t'(node), ADDR_W));
  assign lo        = ADDR_W'(child_lo(word_t'(node), ADDR_W));
  // Feature indices past the vector read as 0.
  assign bit_sel   = int'(fi) < N_FEAT && feat[fi];
  assign abort     = step == STEP_W'(MAX_DEPTH - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE && in_valid) nxt = WALK;
    if (state == WALK && (leaf || abort)) nxt = DONE;
    if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      feat    <= '0;
      cur     <= '0;
      step    <= '0;
      outp    <= '0;
      out_err <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && state != IDLE;
      if (state == IDLE && in_valid) begin
        feat <= inp;
        cur  <= '0;
        step <= '0;
      end
      if (state == WALK) begin
        if (leaf) begin
          outp    <= N_OUT'(lvl_to_therm(leaf_lvl(word_t'(node), LVL_W), N_OUT));
          out_err <= 1'b0;
        end else if (abort) begin
          outp    <= '0;
          out_err <= 1'b1;
        end else begin
          cur  <= bit_sel ? hi : lo;
          step <= step + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_dt_walker.sv
// tb_dt_walker: table-driven walks with a result scoreboard plus hand-written corner sequences.
module tb_dt_walker;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0, cfg_err, in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [5:0] cfg_addr = '0;
  logic [16:0] cfg_wdata = '0;
  logic [9:0] inp = '0, outp;
  int total = 0, passed = 0;
  typedef struct {logic [9:0] outp; logic err; int lat;} exp_t;
  typedef struct {int tree; logic [9:0] inp; logic [9:0] outp; logic err; int lat;} vec_t;
  exp_t sb[$];
  vec_t vecs[7];
  dt_walker dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready), .outp(outp), .out_err(out_err)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] mk_int(input logic [3:0] f, input logic [5:0] h, input logic [5:0] l);
    return {1'b0, f, h, l};
  endfunction
  function automatic logic [16:0] mk_leaf(input logic [3:0] lv);
    return {1'b1, 12'b0, lv};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cfg_write(input logic [5:0] a, input logic [16:0] d);
    @(negedge clk);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 0;
    check("cfg_err_idle", cfg_err, 0);
  endtask
  task automatic load_tree(input int t);
    if (t == 0) begin
      cfg_write(0, mk_int(1, 1, 2));
      cfg_write(1, mk_leaf(5));
      cfg_write(2, mk_int(6, 3, 4));
      cfg_write(3, mk_leaf(7));
      cfg_write(4, mk_leaf(9));
    end else begin
      cfg_write(0, mk_int(0, 5, 6));
      cfg_write(5, mk_int(3, 7, 8));
      cfg_write(7, mk_leaf(0));
      cfg_write(8, mk_leaf(10));
      cfg_write(6, mk_int(12, 9, 10));
      cfg_write(9, mk_leaf(1));
      cfg_write(10, mk_leaf(15));
    end
  endtask
  // hold: cycles of backpressure once the result appears; rej: attempt a write mid-walk;
  // wr: write node 0 in the same cycle as the accepting handshake.
  task automatic do_walk(input logic [9:0] v, input logic [9:0] e_out, input logic e_err,
                         input int e_lat, input int hold, input bit rej, input bit wr,
                         input logic [16:0] wd);
    exp_t e;
    int lat;
    sb.push_back('{e_out, e_err, e_lat});
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; inp = v; out_ready = (hold == 0);
    if (wr) begin cfg_we = 1; cfg_addr = 0; cfg_wdata = wd; end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 0; cfg_we = 0; inp = 10'($urandom);
    while (!out_valid && lat < 40) begin
      if (rej && lat == 1) begin cfg_we = 1; cfg_addr = 4; cfg_wdata = mk_leaf(2); end
      if (rej && lat == 2) begin check("cfg_err_pulse", cfg_err, 1); cfg_we = 0; end
      if (rej && lat == 3) check("cfg_err_drop", cfg_err, 0);
      if (lat > 1) check("in_ready_busy", in_ready, 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!out_valid) begin
      check("walk_timeout", 0, 1);
      out_ready = 1;
      return;
    end
    check("outp", outp, e.outp);
    check("out_err", out_err, e.err);
    check("latency", lat, e.lat);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_outp", outp, e.outp);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask
  initial begin
    vecs[0] = '{0, 10'b0000000010, 10'b0000011111, 0, 3};
    vecs[1] = '{0, 10'b0000000000, 10'b0111111111, 0, 4};
    vecs[2] = '{0, 10'b0001000000, 10'b0001111111, 0, 4};
    vecs[3] = '{0, 10'b1111111111, 10'b0000011111, 0, 3};
    vecs[4] = '{1, 10'b0000001001, 10'b0000000000, 0, 4};
    vecs[5] = '{1, 10'b0000000001, 10'b1111111111, 0, 4};
    vecs[6] = '{1, 10'b1111111110, 10'b1111111111, 0, 4};
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_outp", outp, 0);
    check("rst_err", out_err, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || vecs[i].tree != vecs[i-1].tree) load_tree(vecs[i].tree);
      do_walk(vecs[i].inp, vecs[i].outp, vecs[i].err, vecs[i].lat, 0, 0, 0, '0);
    end
    cfg_write(0, mk_int(1, 1, 2));
    do_walk(10'b10, 10'b0000011111, 0, 3, 10, 0, 0, '0);
    do_walk(10'b0, 10'b0111111111, 0, 4, 0, 1, 0, '0);
    do_walk(10'b0, 10'b0111111111, 0, 4, 0, 0, 0, '0);
    cfg_write(0, 17'b0);
    do_walk(10'h3FF, 10'b0, 1, 17, 0, 0, 0, '0);
    do_walk(10'b0, 10'b0000000111, 0, 2, 0, 0, 1, mk_leaf(3));
    cfg_write(0, mk_int(1, 1, 2));
    @(negedge clk);
    in_valid = 1; inp = 10'b10;
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_outp", outp, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("postrst_valid", out_valid, 0);
    check("postrst_ready", in_ready, 1);
    do_walk(10'b10, 10'b0, 1, 17, 0, 0, 0, '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dt_walker.md
Name: dt_walker

Overview:
- Sequential, parametrised successor to the team's fixed combinational decision-tree classifiers.
- The tree is held in a runtime-loadable node table instead of hard-wired ternaries.
- A feature vector is accepted on a valid/ready handshake, and the tree is walked one node per clock.
- The leaf class is emitted as a thermometer code of the same form the classifiers produce (e.g. level 5 -> 0000011111).

Parameters:
- N_FEAT, 10, number of binary input features.
- N_OUT, 10, thermometer output width; leaf levels 0..N_OUT.
- N_NODES, 64, node table depth.
- MAX_DEPTH, 16, walk-step limit before abort.
- Derived, not overridable:
  - ADDR_W = clog2(N_NODES)
  - FIDX_W = clog2(N_FEAT)
  - LVL_W = clog2(N_OUT+1)
  - NODE_W = 1 + FIDX_W + 2*ADDR_W

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  ADDR_W  node index.
- cfg_wdata  in  NODE_W  node word.
- cfg_err  out  1  one-cycle pulse: write rejected.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  block can accept.
- inp  in  N_FEAT  feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- outp  out  N_OUT  thermometer-coded class.
- out_err  out  1  walk aborted (depth overflow); qualified by out_valid.

Behaviour:
- Node word layout:
  - MSB = leaf flag.
  - Internal node: [NODE_W-2 -: FIDX_W] = feature index; next ADDR_W = child_hi (taken when feature = 1); low ADDR_W = child_lo (taken when feature = 0).
  - Leaf node: low LVL_W bits = level L. Levels above N_OUT saturate to N_OUT.
- Root is node 0. The node table is a register array, read combinationally at the current node index and written synchronously.
- FSM states are IDLE, WALK, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready, capture inp into a feature register, set cur = 0, step = 0, and go to WALK.
  - WALK: examine node[cur] each cycle.
    - Leaf: register outp = (1<<L)-1 and out_err = 0; go to DONE.
    - Internal node: cur <= child selected by feat[fidx]; step <= step+1.
    - If fidx >= N_FEAT, the feature reads as 0.
    - If step == MAX_DEPTH-1 and node[cur] is not a leaf: outp = 0, out_err = 1; go to DONE.
  - DONE: out_valid = 1. outp and out_err are held stable until out_valid && out_ready, then go to IDLE.
- Latency: a leaf at depth d (root = 0) gives out_valid high d+2 clocks after the accepting edge.
- in_ready is high only in IDLE. No overlap of walks; throughput is one vector per walk.
- Config writes:
  - Accepted only in IDLE.
  - cfg_we outside IDLE is ignored and cfg_err pulses for 1 cycle.
  - cfg_we and an in_valid handshake in the same IDLE cycle: the write takes effect and the walk starts at WALK with the updated table.
- Reset (asynchronous, any state, including mid-walk):
  - State = IDLE.
  - Outputs: out_valid = 0, outp = 0, out_err = 0, cfg_err = 0, in_ready = 1 after deassert.
  - The node table resets to all zeros; node 0 is then an internal node with fidx 0 and both children 0, so a walk before configuration ends with out_err.
  - A walk in progress is discarded; no partial result is emitted.
- Captured inp is stable during the walk; changes on inp after acceptance have no effect.

Decomposition:
- Package dt_walker_pkg holds:
  - width functions: ADDR_W, FIDX_W, LVL_W, NODE_W;
  - node field slicing functions: is_leaf, fidx, child_hi, child_lo, leaf_lvl;
  - the FSM state enum;
  - function lvl_to_therm(L) with saturation.
- One sub-module, dt_node_table: register array with a synchronous write port, a combinational read port and asynchronous reset.
- FSM, datapath and thermometer encode stay in dt_walker.

Test Plan:
1. Config and basic walk:
   - Stimulus: load tree node0 = {int, f1, hi=1, lo=2}, node1 = leaf 5, node2 = {int, f6, hi=3, lo=4}, node3 = leaf 7, node4 = leaf 9.
   - inp[1]=1 -> outp = 0000011111, out_valid 3 clocks after accept.
   - inp[1]=0, inp[6]=0 -> outp = 0111111111, latency 4.
2. Backpressure:
   - Stimulus: hold out_ready = 0 for 10 cycles.
   - Response: outp and out_valid stable, in_ready = 0 throughout; release -> IDLE next cycle, in_ready = 1.
3. Depth overflow:
   - Stimulus: node0 children both 0, MAX_DEPTH = 16.
   - Response: out_valid with outp = 0, out_err = 1, 17 clocks after accept.
4. Rejected config write:
   - Stimulus: cfg_we during WALK.
   - Response: cfg_err 1-cycle pulse; table unchanged; result equals the pre-write tree's result.
5. Reset mid-walk:
   - Stimulus: rst_n low in WALK.
   - Response: out_valid = 0 immediately; after release in_ready = 1, table zeroed, unconfigured walk returns out_err = 1.
6. Edge encodings:
   - leaf L = 0 -> outp = 0.
   - L = 10 -> all ones.
   - L = 15 -> saturates to all ones.
   - fidx = 12 -> child_lo taken.
